// File: rtl/md_pkg.sv
// Shared multiply/divide op encoding and class predicates for md_unit, the E-stage decoder and the hazard unit.
// MD_MADD_EN adds the multiply-accumulate group (codes 7..10) to the multiply class.
package md_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    typedef logic [OP_W-1:0] md_op_t;

    localparam md_op_t MD_NONE  = 4'd0;
    localparam md_op_t MD_MULT  = 4'd1;
    localparam md_op_t MD_MULTU = 4'd2;
    localparam md_op_t MD_DIV   = 4'd3;
    localparam md_op_t MD_DIVU  = 4'd4;
    localparam md_op_t MD_MTHI  = 4'd5;
    localparam md_op_t MD_MTLO  = 4'd6;
    localparam md_op_t MD_MADD  = 4'd7;
    localparam md_op_t MD_MADDU = 4'd8;
    localparam md_op_t MD_MSUB  = 4'd9;
    localparam md_op_t MD_MSUBU = 4'd10;

    // One bit per op code; set bits mark members of the class.
`ifdef MD_MADD_EN
    localparam logic [15:0] MD_MULT_CLASS = 16'h0786;
`else
    localparam logic [15:0] MD_MULT_CLASS = 16'h0006;
`endif
    localparam logic [15:0] MD_DIV_CLASS  = 16'h0018;

    function automatic logic md_is_mult(input md_op_t op);
        return MD_MULT_CLASS[op];
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return MD_DIV_CLASS[op];
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result for an issuing op.
// With MD_MADD_EN the current HI/LO are taken in as the accumulator.
module md_core
    import md_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
`ifdef MD_MADD_EN
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] lo,
`endif
    output logic [63:0]       result_c
);

    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W-1:0] q_mag;
    logic [DATA_W-1:0] r_mag;
    logic [DATA_W-1:0] q_s;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] q_u;
    logic [DATA_W-1:0] r_u;

    // Low 64 bits of a sign-extended product equal the signed 32x32 product.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
    end

    // Signed divide via magnitudes; quotient truncates to zero, remainder follows the dividend.
    always_comb begin
        a_neg = a[31];
        b_neg = b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        q_mag = '0;
        r_mag = '0;
        q_u   = '0;
        r_u   = '0;
        if (b != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = a / b;
            r_u   = a % b;
        end
        q_s = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        r_s = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        result_c = '0;
        case (op)
            MD_MULT:  result_c = prod_s;
            MD_MULTU: result_c = prod_u;
            MD_DIV:   result_c = {r_s, q_s};
            MD_DIVU:  result_c = {r_u, q_u};
`ifdef MD_MADD_EN
            MD_MADD:  result_c = {hi, lo} + prod_s;
            MD_MADDU: result_c = {hi, lo} + prod_u;
            MD_MSUB:  result_c = {hi, lo} - prod_s;
            MD_MSUBU: result_c = {hi, lo} - prod_u;
`endif
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: issue, busy countdown and the architectural HI/LO registers.
// Optional multiply-accumulate ops are enabled by defining MD_MADD_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   md_op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              stall_req,
    output logic [DATA_W-1:0] HI_out,
    output logic [DATA_W-1:0] LO_out
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic [DATA_W-1:0] hi_q,      hi_d;
    logic [DATA_W-1:0] lo_q,      lo_d;
    logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
    logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;
    logic              is_mult_c;
    logic              is_div_c;
    logic [63:0]       core_res_c;

    assign is_mult_c = md_is_mult(md_op);
    assign is_div_c  = md_is_div(md_op);

    md_core u_core (
        .op       (md_op),
        .a        (A),
        .b        (B),
`ifdef MD_MADD_EN
        .hi       (hi_q),
        .lo       (lo_q),
`endif
        .result_c (core_res_c)
    );

    // Countdown owns the unit while busy; otherwise accept an issue or a direct HI/LO move.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_d = '0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (is_mult_c || is_div_c) begin
            cnt_d     = is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_hi_d = core_res_c[63:32];
            pend_lo_d = core_res_c[31:0];
            // A zero divisor still burns the full latency but leaves HI/LO alone.
            pend_wr_d = !(is_div_c && (B == '0));
        end else if (md_op == MD_MTHI) begin
            hi_d = A;
        end else if (md_op == MD_MTLO) begin
            lo_d = A;
        end
    end

    assign busy_d = (cnt_d != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy      = busy_q;
    assign stall_req = busy_q | is_mult_c | is_div_c;
    assign HI_out    = hi_q;
    assign LO_out    = lo_q;

endmodule
